led_pwm_ctrl_axil: RTL



---
 rtl/led_ctrl_pkg.sv | 31 +++
 rtl/led_channel.sv | 47 ++++
 rtl/led_pwm_ctrl_axil.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/led_ctrl_pkg.sv
// Shared types, register offsets and response codes for the AXI4-Lite LED controller.
package led_ctrl_pkg;
  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PWM   = 2'd3
  } led_mode_t;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  localparam logic [31:0] CTRL_OFF   = 32'h00;
  localparam logic [31:0] PRESC_OFF  = 32'h04;
  localparam logic [31:0] STATUS_OFF = 32'h08;
  localparam logic [31:0] ID_OFF     = 32'h0C;
  localparam logic [31:0] CH_BASE    = 32'h10;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [15:0] ID_MAGIC    = 16'h1ED0;

  function automatic logic [31:0] apply_strb(input logic [31:0] old, input logic [31:0] data,
                                             input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
    return r;
  endfunction
endpackage

// File: rtl/led_channel.sv
// One LED channel: blink timer plus off/on/blink/PWM output selection.
module led_channel
  import led_ctrl_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic                clr,
  input  logic [1:0]          mode,
  input  logic [PWM_BITS-1:0] duty,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic [7:0]          blink_half,
  output logic                raw
);
  logic [7:0] blink_cnt;
  logic       blink_state;

  // clr wins over tick so a mode change always restarts the blink phase from "off"
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_state <= 1'b0;
    end else if (clr) begin
      blink_cnt   <= '0;
      blink_state <= 1'b0;
    end else if (tick) begin
      if (blink_cnt == blink_half) begin
        blink_cnt   <= '0;
        blink_state <= ~blink_state;
      end else begin
        blink_cnt <= blink_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    raw = 1'b0;
    case (led_mode_t'(mode))
      MODE_ON:    raw = 1'b1;
      MODE_BLINK: raw = blink_state;
      MODE_PWM:   raw = (pwm_cnt < duty);
      default:    raw = 1'b0;
    endcase
  end
endmodule

// File: rtl/led_pwm_ctrl_axil.sv
// AXI4-Lite LED controller: register file, write/read FSMs, shared prescaler and PWM counter.
module led_pwm_ctrl_axil
  import led_ctrl_pkg::*;
#(
  parameter int NUM_LEDS    = 8,
  parameter int PWM_BITS    = 8,
  parameter int PRESC_WIDTH = 16,
  parameter int ADDR_WIDTH  = 8
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [2:0]            s_axi_awprot,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [31:0]           s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [2:0]            s_axi_arprot,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [31:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic [NUM_LEDS-1:0]   led_out,
  output logic                  pwm_sync
);
  localparam logic [31:0]         CH_END  = CH_BASE + 32'(4 * NUM_LEDS);
  localparam logic [PWM_BITS-1:0] PWM_MAX = '1;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic [1:0]                         ctrl;
  logic [PRESC_WIDTH-1:0]             presc, presc_cnt;
  logic [NUM_LEDS-1:0][1:0]           ch_mode;
  logic [NUM_LEDS-1:0][PWM_BITS-1:0]  ch_duty;
  logic [NUM_LEDS-1:0][7:0]           ch_half;
  logic [NUM_LEDS-1:0][31:0]          ch_word;
  logic [NUM_LEDS-1:0]                ch_clr, raw;
  logic [PWM_BITS-1:0]                pwm_cnt;
  logic                               tick, presc_wr;

  logic                  aw_held, w_held, aw_hs, w_hs, commit;
  logic [ADDR_WIDTH-1:0] aw_addr_q, wr_addr;
  logic [31:0]           w_data_q, wr_data, wa, ra, merged;
  logic [3:0]            w_strb_q, wr_strb;
  logic                  unused;

  function automatic logic [31:0] reg_sel(input logic [31:0] a, input logic [1:0] c,
                                          input logic [PRESC_WIDTH-1:0] p,
                                          input logic [NUM_LEDS-1:0] st,
                                          input logic [NUM_LEDS-1:0][31:0] chw);
    logic [31:0] r;
    r = '0;
    if (a == CTRL_OFF)        r = {30'd0, c};
    else if (a == PRESC_OFF)  r = 32'(p);
    else if (a == STATUS_OFF) r = 32'(st);
    else if (a == ID_OFF)     r = {8'(NUM_LEDS), 8'(PWM_BITS), ID_MAGIC};
    else
      for (int i = 0; i < NUM_LEDS; i++)
        if (a == CH_BASE + 32'(4 * i)) r = chw[i];
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_LEDS; i++) begin
      ch_word[i]               = '0;
      ch_word[i][1:0]          = ch_mode[i];
      ch_word[i][8+:PWM_BITS]  = ch_duty[i];
      ch_word[i][31:24]        = ch_half[i];
    end
  end

  // AW and W may arrive in either order; whichever comes first is parked until its partner shows up
  assign aw_hs   = s_axi_awvalid && s_axi_awready;
  assign w_hs    = s_axi_wvalid && s_axi_wready;
  assign commit  = (w_state == W_IDLE) && (aw_held || s_axi_awvalid) && (w_held || s_axi_wvalid);
  assign wr_addr = aw_held ? aw_addr_q : s_axi_awaddr;
  assign wr_data = w_held ? w_data_q : s_axi_wdata;
  assign wr_strb = w_held ? w_strb_q : s_axi_wstrb;
  assign wa      = 32'(wr_addr) & 32'hFFFF_FFFC;
  assign ra      = 32'(s_axi_araddr) & 32'hFFFF_FFFC;
  assign merged  = apply_strb(reg_sel(wa, ctrl, presc, led_out, ch_word), wr_data, wr_strb);
  assign presc_wr = commit && (wa == PRESC_OFF);
  assign unused  = ^{s_axi_awprot, s_axi_arprot, merged};

  always_comb begin
    for (int i = 0; i < NUM_LEDS; i++)
      ch_clr[i] = commit && (wa == CH_BASE + 32'(4 * i)) && (merged[1:0] != ch_mode[i]);
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  always_comb begin
    w_next = w_state;
    r_next = r_state;
    case (w_state)
      W_IDLE:  if (commit) w_next = W_RESP;
      W_RESP:  if (s_axi_bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
    case (r_state)
      R_IDLE:  if (s_axi_arvalid) r_next = R_DATA;
      R_DATA:  if (s_axi_rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    s_axi_awready = (w_state == W_IDLE) && !aw_held;
    s_axi_wready  = (w_state == W_IDLE) && !w_held;
    s_axi_bvalid  = (w_state == W_RESP);
    s_axi_arready = (r_state == R_IDLE);
    s_axi_rvalid  = (r_state == R_DATA);
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_held     <= 1'b0;
      w_held      <= 1'b0;
      aw_addr_q   <= '0;
      w_data_q    <= '0;
      w_strb_q    <= '0;
      s_axi_bresp <= RESP_OKAY;
    end else if (commit) begin
      aw_held     <= 1'b0;
      w_held      <= 1'b0;
      s_axi_bresp <= (wa < CH_END) ? RESP_OKAY : RESP_SLVERR;
    end else begin
      if (aw_hs) begin
        aw_held   <= 1'b1;
        aw_addr_q <= s_axi_awaddr;
      end
      if (w_hs) begin
        w_held   <= 1'b1;
        w_data_q <= s_axi_wdata;
        w_strb_q <= s_axi_wstrb;
      end
    end
  end

  // Read samples the registers before this cycle's write lands, so a colliding read sees old data
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      s_axi_rdata <= '0;
      s_axi_rresp <= RESP_OKAY;
    end else if (s_axi_arvalid && s_axi_arready) begin
      s_axi_rdata <= (ra < CH_END) ? reg_sel(ra, ctrl, presc, led_out, ch_word) : 32'd0;
      s_axi_rresp <= (ra < CH_END) ? RESP_OKAY : RESP_SLVERR;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      ctrl    <= '0;
      presc   <= '0;
      ch_mode <= '0;
      ch_duty <= '0;
      ch_half <= '0;
    end else if (commit && (wa < CH_END)) begin
      if (wa == CTRL_OFF)  ctrl  <= merged[1:0];
      if (wa == PRESC_OFF) presc <= merged[PRESC_WIDTH-1:0];
      for (int i = 0; i < NUM_LEDS; i++)
        if (wa == CH_BASE + 32'(4 * i)) begin
          ch_mode[i] <= merged[1:0];
          ch_duty[i] <= merged[8+:PWM_BITS];
          ch_half[i] <= merged[31:24];
        end
    end
  end

  assign tick = (presc_cnt == presc);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      presc_cnt <= '0;
      pwm_cnt   <= '0;
      pwm_sync  <= 1'b0;
      led_out   <= '0;
    end else begin
      pwm_sync <= tick && (pwm_cnt == PWM_MAX);
      if (presc_wr || tick) presc_cnt <= '0;
      else                  presc_cnt <= presc_cnt + PRESC_WIDTH'(1);
      if (tick) pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      led_out <= ctrl[0] ? (raw ^ {NUM_LEDS{ctrl[1]}}) : {NUM_LEDS{ctrl[1]}};
    end
  end

  for (genvar g = 0; g < NUM_LEDS; g++) begin : g_ch
    led_channel #(.PWM_BITS(PWM_BITS)) u_ch (
      .clk        (ACLK),
      .rst        (ARESET),
      .tick       (tick),
      .clr        (ch_clr[g]),
      .mode       (ch_mode[g]),
      .duty       (ch_duty[g]),
      .pwm_cnt    (pwm_cnt),
      .blink_half (ch_half[g]),
      .raw        (raw[g])
    );
  end
endmodule
